// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - source/write-port bundle for the writeback arbiter
//
// Purpose: groups the result-source handshake and the two register-file
//          write ports of wb_arbiter into one interface.
// Signals:
//   stall                          backend stall
//   src_valid/src_preg/src_data    per-source result offer (packed by index)
//   src_ready                      per-source FIFO can accept
//   reg_to_update1/new_value1/update1   write port 1
//   reg_to_update2/new_value2/update2   write port 2
//   pending                        any source FIFO non-empty
// Modports: master drives the sources and observes the ports (bench / backend),
//           slave is the arbiter itself.

interface wb_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int PREG_W  = 6,
  parameter int DATA_W  = 32
);
  logic                        stall;
  logic [NUM_SRC-1:0]          src_valid;
  logic [NUM_SRC*PREG_W-1:0]   src_preg;
  logic [NUM_SRC*DATA_W-1:0]   src_data;
  logic [NUM_SRC-1:0]          src_ready;
  logic [PREG_W-1:0]           reg_to_update1;
  logic [DATA_W-1:0]           new_value1;
  logic                        update1;
  logic [PREG_W-1:0]           reg_to_update2;
  logic [DATA_W-1:0]           new_value2;
  logic                        update2;
  logic                        pending;

  modport master (
    output stall, src_valid, src_preg, src_data,
    input  src_ready, reg_to_update1, new_value1, update1,
           reg_to_update2, new_value2, update2, pending
  );

  modport slave (
    input  stall, src_valid, src_preg, src_data,
    output src_ready, reg_to_update1, new_value1, update1,
           reg_to_update2, new_value2, update2, pending
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter feeding two register-file write ports
//
// Purpose: buffers results from NUM_SRC execution units in per-source FIFOs
//          and each cycle grants up to two FIFO heads, round-robin, onto the
//          register file's two write ports (registered outputs).
// Ports:
//   clk    clock, all state on posedge
//   reset  synchronous active-high reset
//   bus    wb_arbiter_if.slave: source handshake in, write ports/pending out

module wb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int PREG_W  = 6,
  parameter int DATA_W  = 32,
  parameter int QDEPTH  = 2
) (
  input  logic            clk,
  input  logic            reset,
  wb_arbiter_if.slave     bus
);

  localparam int SW = $clog2(NUM_SRC);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PREG_W + DATA_W;
  localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);
  localparam logic [SW:0]   NUM_C    = (SW+1)'(NUM_SRC);

  // (base + off) mod NUM_SRC, valid for base < NUM_SRC and off <= NUM_SRC
  function automatic logic [SW-1:0] add_mod(input logic [SW-1:0] base,
                                            input logic [SW:0]   off);
    logic [SW:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= NUM_C) sum = sum - NUM_C;
    return sum[SW-1:0];
  endfunction

  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] deq;
  logic [EW-1:0]      head [NUM_SRC];

  logic [SW-1:0]      rr_ptr;
  logic               g1_valid, g2_valid;
  logic [SW-1:0]      g1_idx, g2_idx;
  logic [SW-1:0]      scan_idx;
  logic [SW-1:0]      rr_next;

  // Per-source FIFOs; src_ready looks only at the stored count so a full
  // FIFO being drained this cycle still refuses a new entry.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [EW-1:0] mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          enq;

    assign ready[i]    = count < QDEPTH_C;
    assign nonempty[i] = count != '0;
    assign enq         = bus.src_valid[i] && ready[i];
    assign head[i]     = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) begin
          mem[wr_ptr] <= {bus.src_preg[i*PREG_W +: PREG_W],
                          bus.src_data[i*DATA_W +: DATA_W]};
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (deq[i]) rd_ptr <= rd_ptr + 1'b1;
        case ({enq, deq[i]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assign bus.src_ready = ready;
  assign bus.pending   = |nonempty;

  // Scan starting at rr_ptr; the first two non-empty sources win ports 1 and 2.
  always_comb begin
    g1_valid = 1'b0;
    g1_idx   = '0;
    g2_valid = 1'b0;
    g2_idx   = '0;
    scan_idx = '0;
    deq      = '0;
    if (!bus.stall) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        scan_idx = add_mod(rr_ptr, (SW+1)'(k));
        if (nonempty[scan_idx]) begin
          if (!g1_valid) begin
            g1_valid = 1'b1;
            g1_idx   = scan_idx;
          end else if (!g2_valid) begin
            g2_valid = 1'b1;
            g2_idx   = scan_idx;
          end
        end
      end
    end
    if (g1_valid) deq[g1_idx] = 1'b1;
    if (g2_valid) deq[g2_idx] = 1'b1;
    rr_next = add_mod(g2_valid ? g2_idx : g1_idx, (SW+1)'(1));
  end

  // Unused ports drop update but keep their last tag/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr             <= '0;
      bus.update1        <= 1'b0;
      bus.update2        <= 1'b0;
      bus.reg_to_update1 <= '0;
      bus.new_value1     <= '0;
      bus.reg_to_update2 <= '0;
      bus.new_value2     <= '0;
    end else begin
      bus.update1 <= g1_valid;
      bus.update2 <= g2_valid;
      if (g1_valid) begin
        bus.reg_to_update1 <= head[g1_idx][EW-1 -: PREG_W];
        bus.new_value1     <= head[g1_idx][DATA_W-1:0];
        rr_ptr             <= rr_next;
      end
      if (g2_valid) begin
        bus.reg_to_update2 <= head[g2_idx][EW-1 -: PREG_W];
        bus.new_value2     <= head[g2_idx][DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter

module tb_wb_arbiter;
  localparam int NS = 4;
  localparam int PW = 6;
  localparam int DW = 32;
  localparam int QD = 2;

  logic clk;
  logic reset;

  wb_arbiter_if #(.NUM_SRC(NS), .PREG_W(PW), .DATA_W(DW)) bus_if ();

  wb_arbiter #(.NUM_SRC(NS), .PREG_W(PW), .DATA_W(DW), .QDEPTH(QD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue of {tag,data} per source plus a round-robin start index.
  logic [PW+DW-1:0] q [NS][$];
  int               rr = 0;
  bit               primed = 1'b0;
  logic             exp_u1, exp_u2;
  logic [PW-1:0]    exp_t1, exp_t2;
  logic [DW-1:0]    exp_d1, exp_d2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input bit v, input logic [PW-1:0] t, input logic [DW-1:0] d);
    bus_if.src_valid[i]        = v;
    bus_if.src_preg[i*PW +: PW] = t;
    bus_if.src_data[i*DW +: DW] = d;
  endtask

  // One clock: predict from current inputs, clock, then compare all outputs.
  task automatic step();
    logic [NS-1:0]    rdy;
    int               g[$];
    int               idx;
    logic [PW+DW-1:0] e;
    bit               any;
    for (int i = 0; i < NS; i++) rdy[i] = (q[i].size() < QD);
    if (primed) chk("src_ready", 64'(bus_if.src_ready), 64'(rdy));
    if (reset) begin
      for (int i = 0; i < NS; i++) q[i].delete();
      rr = 0;
      exp_u1 = 0; exp_u2 = 0;
      exp_t1 = '0; exp_t2 = '0; exp_d1 = '0; exp_d2 = '0;
    end else begin
      if (!bus_if.stall)
        for (int k = 0; k < NS; k++) begin
          idx = (rr + k) % NS;
          if (q[idx].size() > 0 && g.size() < 2) g.push_back(idx);
        end
      exp_u1 = (g.size() > 0);
      exp_u2 = (g.size() > 1);
      if (g.size() > 0) begin
        e = q[g[0]].pop_front();
        exp_t1 = e[PW+DW-1:DW]; exp_d1 = e[DW-1:0];
        rr = (g[g.size()-1] + 1) % NS;
      end
      if (g.size() > 1) begin
        e = q[g[1]].pop_front();
        exp_t2 = e[PW+DW-1:DW]; exp_d2 = e[DW-1:0];
      end
      for (int i = 0; i < NS; i++)
        if (bus_if.src_valid[i] && rdy[i])
          q[i].push_back({bus_if.src_preg[i*PW +: PW], bus_if.src_data[i*DW +: DW]});
    end
    @(posedge clk);
    #1;
    primed = 1'b1;
    any = 1'b0;
    for (int i = 0; i < NS; i++) if (q[i].size() > 0) any = 1'b1;
    chk("update1", 64'(bus_if.update1), 64'(exp_u1));
    chk("update2", 64'(bus_if.update2), 64'(exp_u2));
    chk("tag1",    64'(bus_if.reg_to_update1), 64'(exp_t1));
    chk("data1",   64'(bus_if.new_value1), 64'(exp_d1));
    chk("tag2",    64'(bus_if.reg_to_update2), 64'(exp_t2));
    chk("data2",   64'(bus_if.new_value2), 64'(exp_d2));
    chk("pending", 64'(bus_if.pending), 64'(any));
  endtask

  task automatic clear_src();
    for (int i = 0; i < NS; i++) set_src(i, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus_if.stall = 1'b0;
    clear_src();

    // reset state
    do_reset();
    chk("rst_update1", 64'(bus_if.update1), 64'd0);
    chk("rst_ready",   64'(bus_if.src_ready), 64'hF);

    // single result, minimum latency
    set_src(0, 1'b1, 6'd5, 32'hDEAD);
    step();
    chk("t1_no_bypass", 64'(bus_if.update1), 64'd0);
    clear_src();
    step();
    chk("t1_update1", 64'(bus_if.update1), 64'd1);
    chk("t1_tag1",    64'(bus_if.reg_to_update1), 64'd5);
    chk("t1_data1",   64'(bus_if.new_value1), 64'hDEAD);
    chk("t1_pending", 64'(bus_if.pending), 64'd0);

    // all four sources, rr starting at 0
    do_reset();
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 6'(10 + i), 32'(100 + i));
    step();
    clear_src();
    step();
    chk("t2_c1_tags", 64'({bus_if.reg_to_update1, bus_if.reg_to_update2}), 64'({6'd10, 6'd11}));
    step();
    chk("t2_c2_tags", 64'({bus_if.reg_to_update1, bus_if.reg_to_update2}), 64'({6'd12, 6'd13}));
    set_src(1, 1'b1, 6'd30, 32'h30);
    step();
    clear_src();
    step();
    chk("t2_rr_back", 64'(bus_if.reg_to_update1), 64'd30);

    // stall with source 2 held valid
    do_reset();
    bus_if.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_src(2, 1'b1, 6'(20 + k), 32'(200 + k));
      step();
      if (k == 1) chk("t3_ready2_low", 64'(bus_if.src_ready[2]), 64'd0);
    end
    bus_if.stall = 1'b0;
    clear_src();
    step();
    chk("t3_first", 64'(bus_if.reg_to_update1), 64'd20);
    step();
    chk("t3_second", 64'(bus_if.reg_to_update1), 64'd21);
    step();

    // fairness between sources 0 and 3 starting from rr=3
    for (int k = 0; k < 8; k++) begin
      set_src(0, 1'b1, 6'(32 + k), 32'(300 + k));
      set_src(3, 1'b1, 6'(48 + k), 32'(400 + k));
      step();
      if (k > 0) chk("t4_both", 64'({bus_if.update1, bus_if.update2}), 64'b11);
    end
    clear_src();
    step();

    // reset with five entries buffered
    bus_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, 6'(i + 1), 32'(i));
    step();
    set_src(2, 1'b0, '0, '0);
    step();
    clear_src();
    bus_if.stall = 1'b0;
    do_reset();
    chk("t5_ready",   64'(bus_if.src_ready), 64'hF);
    chk("t5_pending", 64'(bus_if.pending), 64'd0);
    chk("t5_updates", 64'({bus_if.update1, bus_if.update2}), 64'd0);

    // simultaneous enqueue/dequeue on a one-entry FIFO
    set_src(1, 1'b1, 6'd1, 32'h1000);
    step();
    for (int k = 2; k <= 11; k++) begin
      set_src(1, 1'b1, 6'(k), 32'(32'h1000 + k));
      step();
      chk("t6_order",   64'(bus_if.reg_to_update1), 64'(k - 1));
      chk("t6_pending", 64'(bus_if.pending), 64'd1);
    end
    clear_src();
    step();

    // randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      bus_if.stall = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < NS; i++)
        set_src(i, 1'($urandom_range(0, 1)), 6'($urandom), $urandom);
      step();
    end
    reset = 1'b0;
    bus_if.stall = 1'b0;
    clear_src();
    for (int c = 0; c < 6; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
